// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: instruction field positions and the queue entry type.
package fetch_pkg;

  localparam int OPC_HI   = 15;
  localparam int OPC_LO   = 10;
  localparam int SRC_HI   = 9;
  localparam int SRC_LO   = 7;
  localparam int DST_HI   = 6;
  localparam int DST_LO   = 4;
  localparam int SHAMT_HI = 3;
  localparam int SHAMT_LO = 0;

  localparam logic [OPC_HI-OPC_LO:0] NOP_OPC = '0;

  localparam int ENTRY_PC_W    = 32;
  localparam int ENTRY_INSTR_W = 16;

  typedef struct packed {
    logic [ENTRY_PC_W-1:0]    pc;
    logic [ENTRY_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding fetched {pc, instr} entries; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output entry_t                     head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CNT_W'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous ROM read, prefetch queue, decode handshake and redirect.
// Optional FETCH_PERF_CNT_EN adds saturating pop/stall counters. ROM image is supplied through ROM_INIT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               PC_W        = 32,
  parameter int               INSTR_W     = 16,
  parameter int               ADDR_W      = 10,
  parameter int               QUEUE_DEPTH = 4,
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] ROM_INIT [2**ADDR_W] = '{default: '0}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         opcode,
  output logic [2:0]         src,
  output logic [2:0]         dst,
  output logic [3:0]         shiftamount,
  output logic [PC_W-1:0]    fetch_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]    rd_pc_q, rd_pc_d;
  logic [INSTR_W-1:0] rd_data_q, rd_data_d;
  logic               inflight_q, inflight_d;
  logic               issue, push, pop;
  logic [CNT_W:0]     occupancy;
  logic [CNT_W-1:0]   q_count;
  entry_t             q_head, q_push_data;

  // Credit check counts the read in flight so a returning word always has a free slot.
  always_comb begin
    occupancy   = (CNT_W+1)'(q_count) + (CNT_W+1)'(inflight_q);
    issue       = !redirect_en && (occupancy < (CNT_W+1)'(QUEUE_DEPTH));
    push        = inflight_q && !redirect_en;
    pop         = out_valid && out_ready && !redirect_en;
    fetch_pc_d  = fetch_pc_q;
    rd_pc_d     = rd_pc_q;
    rd_data_d   = rd_data_q;
    inflight_d  = issue;
    if (redirect_en) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
      rd_pc_d    = fetch_pc_q;
      rd_data_d  = ROM_INIT[fetch_pc_q[ADDR_W-1:0]];
    end
    q_push_data = '{pc: rd_pc_q, instr: rd_data_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_pc_q    <= '0;
      rd_data_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_pc_q    <= rd_pc_d;
      rd_data_q  <= rd_data_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (q_push_data),
    .pop       (pop),
    .flush     (redirect_en),
    .count     (q_count),
    .head      (q_head)
  );

  always_comb begin
    out_valid   = (q_count != '0);
    out_instr   = out_valid ? q_head.instr : '0;
    out_pc      = out_valid ? q_head.pc : '0;
    opcode      = out_valid ? out_instr[OPC_HI:OPC_LO] : NOP_OPC;
    src         = out_instr[SRC_HI:SRC_LO];
    dst         = out_instr[DST_HI:DST_LO];
    shiftamount = out_instr[SHAMT_HI:SHAMT_LO];
    fetch_pc    = fetch_pc_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (pop && (perf_fetched_q != '1)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (out_valid && !out_ready && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random ready/redirect traffic
// compared every cycle against a queue-based transaction model.
module tb_fetch_unit;

  localparam int PC_W   = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  localparam logic [15:0] TB_ROM [16] = '{
    16'h2D15, 16'hA0B1, 16'hC3C2, 16'hD4D3, 16'hE5E4, 16'h16F5, 16'h2706, 16'h3817,
    16'h4928, 16'h5A39, 16'h6B4A, 16'h7C5B, 16'h8D6C, 16'h9E7D, 16'hAF8E, 16'hF09F
  };

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_en = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [15:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [5:0]      opcode;
  logic [2:0]      src;
  logic [2:0]      dst;
  logic [3:0]      shiftamount;
  logic [PC_W-1:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stall;
`endif

  fetch_unit #(
    .PC_W        (PC_W),
    .INSTR_W     (16),
    .ADDR_W      (ADDR_W),
    .QUEUE_DEPTH (DEPTH),
    .RESET_PC    (8'h00),
    .ROM_INIT    (TB_ROM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .opcode       (opcode),
    .src          (src),
    .dst          (dst),
    .shiftamount  (shiftamount),
    .fetch_pc     (fetch_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: words ready for decode, one pending ROM return, and the next address to read.
  int unsigned mq[$];
  bit          p_vld = 1'b0;
  int unsigned p_pc  = 0;
  int unsigned np    = 0;
`ifdef FETCH_PERF_CNT_EN
  longint unsigned m_fetched = 0;
  longint unsigned m_stall   = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    p_vld = 1'b0;
    np    = 0;
`ifdef FETCH_PERF_CNT_EN
    m_fetched = 0;
    m_stall   = 0;
`endif
  endtask

  task automatic model_edge(input bit redir, input int unsigned rpc, input bit rdy);
    bit has_head;
    bit can_issue;
    has_head  = (mq.size() > 0);
    can_issue = (mq.size() + int'(p_vld)) < DEPTH;
`ifdef FETCH_PERF_CNT_EN
    if (has_head && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (!redir && has_head && rdy && m_fetched < 64'hFFFF_FFFF) m_fetched++;
`endif
    if (redir) begin
      mq.delete();
      p_vld = 1'b0;
      np    = rpc % 256;
    end else begin
      if (has_head && rdy) void'(mq.pop_front());
      if (p_vld) mq.push_back(p_pc);
      p_vld = can_issue;
      if (can_issue) begin
        p_pc = np;
        np   = (np + 1) % 256;
      end
    end
  endtask

  task automatic check_all();
    bit          v;
    int unsigned hp;
    logic [15:0] hi;
    v  = (mq.size() > 0);
    hp = v ? mq[0] : 0;
    hi = v ? TB_ROM[hp % 16] : 16'h0;
    chk("out_valid",   32'(out_valid),   32'(v));
    chk("out_pc",      32'(out_pc),      hp);
    chk("out_instr",   32'(out_instr),   32'(hi));
    chk("opcode",      32'(opcode),      (32'(hi) >> 10) & 32'h3F);
    chk("src",         32'(src),         (32'(hi) >> 7) & 32'h7);
    chk("dst",         32'(dst),         (32'(hi) >> 4) & 32'h7);
    chk("shiftamount", 32'(shiftamount), 32'(hi) & 32'hF);
    chk("fetch_pc",    32'(fetch_pc),    np);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 32'(m_fetched));
    chk("perf_stall",   perf_stall,   32'(m_stall));
`endif
  endtask

  task automatic step(input bit redir, input int unsigned rpc, input bit rdy);
    logic [31:0] rpc_v;
    rpc_v       = rpc;
    redirect_en = redir;
    redirect_pc = rpc_v[PC_W-1:0];
    out_ready   = rdy;
    @(posedge clk);
    model_edge(redir, rpc, rdy);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // Reset held for three cycles: nothing valid, PC parked at the reset address.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid",    32'(out_valid), 32'd0);
      chk("rst_fetch_pc", 32'(fetch_pc),  32'd0);
    end
    rst = 1'b0;
    model_reset();

    step(1'b0, 0, 1'b1);
    chk("first_edge_valid", 32'(out_valid), 32'd0);
    step(1'b0, 0, 1'b1);
    chk("first_head_pc", 32'(out_pc),      32'd0);
    chk("field_opcode",  32'(opcode),      32'b001011);
    chk("field_src",     32'(src),         32'b010);
    chk("field_dst",     32'(dst),         32'b001);
    chk("field_shamt",   32'(shiftamount), 32'b0101);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1);

    // Backpressure: fetch stops once queue plus in-flight read reach the depth.
    step(1'b1, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b0);
    chk("bp_fetch_pc", 32'(fetch_pc),  32'd4);
    chk("bp_head_pc",  32'(out_pc),    32'd0);
    chk("bp_head",     32'(out_instr), 32'h2D15);
    for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1);

    // Redirect with three entries queued.
    step(1'b1, 8, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);
    chk("three_queued_pc", 32'(out_pc), 32'd8);
    step(1'b1, 32'h20, 1'b0);
    chk("redir_valid0", 32'(out_valid), 32'd0);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    chk("redir_head_pc", 32'(out_pc),    32'h20);
    chk("redir_head",    32'(out_instr), 32'(TB_ROM[0]));

    // Redirect coinciding with an accepted head, then back-to-back redirects.
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
    step(1'b1, 5, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
    step(1'b1, 32'h40, 1'b1);
    step(1'b1, 7, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);

    // ROM index wrap and PC wrap.
    step(1'b1, 15, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);
    step(1'b1, 8'hFE, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);

    // Asynchronous reset mid-stream clears outputs without waiting for a clock.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_valid",    32'(out_valid), 32'd0);
    chk("async_rst_instr",    32'(out_instr), 32'd0);
    chk("async_rst_pc",       32'(out_pc),    32'd0);
    chk("async_rst_fetch_pc", 32'(fetch_pc),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      bit r;
      bit rd;
      r  = ($urandom_range(0, 15) == 0);
      rd = ($urandom_range(0, 3) != 0);
      step(r, $urandom_range(0, 255), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
